// File: rtl/regfile_param.sv
// Parametrised integer register file: N combinational read ports, one write-back port,
// same-cycle write bypass, optional hardwired x0, pending-write scoreboard, post-reset clear sweep.
module regfile_param #(
    parameter int unsigned  XLEN     = 32,
    parameter int unsigned  NREGS    = 32,
    parameter int unsigned  NREAD    = 2,
    parameter int unsigned  BYPASS   = 1,
    parameter int unsigned  ZERO_REG = 1,
    localparam int unsigned AW       = $clog2(NREGS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NREAD*AW-1:0]   raddr_i,
    output logic [NREAD*XLEN-1:0] rdata_o,
    output logic [NREAD-1:0]      rbusy_o,
    input  logic                  wen_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [XLEN-1:0]       wdata_i,
    input  logic                  set_busy_i,
    input  logic [AW-1:0]         busy_addr_i,
    output logic                  ready_o
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 1);
    localparam bit            BYP       = (BYPASS != 0);
    localparam bit            ZR        = (ZERO_REG != 0);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [NREGS-1:0]  busy_q, busy_d;
    logic [XLEN-1:0]   mem_q [NREGS];

    logic              mem_we_c;
    logic [AW-1:0]     mem_wa_c;
    logic [XLEN-1:0]   mem_wd_c;

    // Sweep / run control, scoreboard update and the single array write port
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        mem_we_c = 1'b0;
        mem_wa_c = cnt_q;
        mem_wd_c = '0;
        case (state_q)
            ST_INIT: begin
                mem_we_c = 1'b1;
                cnt_d    = AW'(cnt_q + 1'b1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (wen_i && !(ZR && (waddr_i == '0))) begin
                    mem_we_c = 1'b1;
                    mem_wa_c = waddr_i;
                    mem_wd_c = wdata_i;
                end
                // Clear first so a same-address set from the younger issuing instruction wins
                if (wen_i) begin
                    busy_d[waddr_i] = 1'b0;
                end
                if (set_busy_i) begin
                    busy_d[busy_addr_i] = 1'b1;
                end
                if (ZR) begin
                    busy_d[0] = 1'b0;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Storage array has no reset so it can map onto RAM; the sweep initialises it
    always_ff @(posedge clk_i) begin
        if (rst_ni && mem_we_c) begin
            mem_q[mem_wa_c] <= mem_wd_c;
        end
    end

    assign ready_o = (state_q == ST_RUN);

    for (genvar g = 0; g < NREAD; g++) begin : g_rd
        logic [AW-1:0] ra;
        logic          hit;
        logic          force_zero;
        assign ra         = raddr_i[g*AW +: AW];
        assign hit        = BYP && wen_i && (waddr_i == ra);
        assign force_zero = (state_q != ST_RUN) || (ZR && (ra == '0));
        assign rdata_o[g*XLEN +: XLEN] = force_zero ? '0 : (hit ? wdata_i : mem_q[ra]);
        assign rbusy_o[g]              = !force_zero && !hit && busy_q[ra];
    end

endmodule

// File: tb/tb_regfile_param.sv
// Directed-vector bench for regfile_param: default, no-bypass/no-x0 and 4-port 64-bit variants.
module tb_regfile_param;

    logic clk;
    logic rst_n;

    logic [9:0]  a_raddr;
    logic        a_wen;
    logic [4:0]  a_waddr;
    logic [31:0] a_wdata;
    logic        a_sb;
    logic [4:0]  a_baddr;
    logic [63:0] a_rdata, b_rdata;
    logic [1:0]  a_rbusy, b_rbusy;
    logic        a_ready, b_ready;

    logic [15:0]  c_raddr;
    logic         c_wen;
    logic [3:0]   c_waddr;
    logic [63:0]  c_wdata;
    logic         c_sb;
    logic [3:0]   c_baddr;
    logic [255:0] c_rdata;
    logic [3:0]   c_rbusy;
    logic         c_ready;

    int n_cmp;
    int n_bad;

    regfile_param u_a (
        .clk_i(clk), .rst_ni(rst_n), .raddr_i(a_raddr), .rdata_o(a_rdata), .rbusy_o(a_rbusy),
        .wen_i(a_wen), .waddr_i(a_waddr), .wdata_i(a_wdata), .set_busy_i(a_sb),
        .busy_addr_i(a_baddr), .ready_o(a_ready)
    );

    regfile_param #(.BYPASS(0), .ZERO_REG(0)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .raddr_i(a_raddr), .rdata_o(b_rdata), .rbusy_o(b_rbusy),
        .wen_i(a_wen), .waddr_i(a_waddr), .wdata_i(a_wdata), .set_busy_i(a_sb),
        .busy_addr_i(a_baddr), .ready_o(b_ready)
    );

    regfile_param #(.XLEN(64), .NREGS(16), .NREAD(4)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .raddr_i(c_raddr), .rdata_o(c_rdata), .rbusy_o(c_rbusy),
        .wen_i(c_wen), .waddr_i(c_waddr), .wdata_i(c_wdata), .set_busy_i(c_sb),
        .busy_addr_i(c_baddr), .ready_o(c_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        sb;
        logic [4:0]  ba;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] ad0;
        logic        ab0;
        logic [31:0] ad1;
        logic [31:0] bd0;
        logic        bb0;
        logic [31:0] bd1;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        a_wen   = 1'b0;
        a_waddr = '0;
        a_wdata = '0;
        a_sb    = 1'b0;
        a_baddr = '0;
    endtask

    logic [63:0] m [16];
    logic [15:0] mb;
    int          cyc;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        // wen wa wd sb ba ra0 ra1 | u_a: d0 b0 d1 | u_b: d0 b0 d1
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 5'd5,  5'd5,  32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0, 32'h0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd5,  5'd0,  32'hDEADBEEF, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 5'd0,  32'h12345678, 1'b1, 5'd0, 5'd0,  5'd5,  32'h0,        1'b0, 32'hDEADBEEF, 32'h0,        1'b0, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd0,  5'd0,  32'h0,        1'b0, 32'h0,        32'h12345678, 1'b1, 32'h12345678};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 5'd7,  5'd0,  32'h0,        1'b0, 32'h0,        32'h0,        1'b0, 32'h12345678};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd7,  5'd7,  32'h0,        1'b1, 32'h0,        32'h0,        1'b1, 32'h0};
        vecs[6]  = '{1'b1, 5'd7,  32'hCAFE0007, 1'b0, 5'd0, 5'd7,  5'd5,  32'hCAFE0007, 1'b0, 32'hDEADBEEF, 32'h0,        1'b1, 32'hDEADBEEF};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd7,  5'd0,  32'hCAFE0007, 1'b0, 32'h0,        32'hCAFE0007, 1'b0, 32'h12345678};
        vecs[8]  = '{1'b1, 5'd9,  32'h00000099, 1'b1, 5'd9, 5'd9,  5'd7,  32'h00000099, 1'b0, 32'hCAFE0007, 32'h0,        1'b0, 32'hCAFE0007};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd9,  5'd9,  32'h00000099, 1'b1, 32'h00000099, 32'h00000099, 1'b1, 32'h00000099};
        vecs[10] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd31, 5'd30, 32'hFFFFFFFF, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd31, 5'd31, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF};
        vecs[12] = '{1'b1, 5'd5,  32'h00000055, 1'b0, 5'd0, 5'd5,  5'd5,  32'h00000055, 1'b0, 32'h00000055, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};

        rst_n   = 1'b0;
        a_raddr = '0;
        a_idle();
        c_raddr = '0;
        c_wen   = 1'b0;
        c_waddr = '0;
        c_wdata = '0;
        c_sb    = 1'b0;
        c_baddr = '0;

        // Reset for three edges, then the sweep
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready_a", 64'(a_ready), 64'd0);
        chk("reset_ready_c", 64'(c_ready), 64'd0);
        chk("reset_rbusy_a", 64'(a_rbusy), 64'd0);
        rst_n = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            tick();
            if (c == 15) chk("sweep16_not_ready", 64'(c_ready), 64'd0);
            if (c == 16) chk("sweep16_ready", 64'(c_ready), 64'd1);
            if (c == 31) chk("sweep32_not_ready", 64'(a_ready), 64'd0);
            if (c == 32) begin
                chk("sweep32_ready_a", 64'(a_ready), 64'd1);
                chk("sweep32_ready_b", 64'(b_ready), 64'd1);
            end
            if (c == 19) begin
                a_wen   = 1'b1;
                a_waddr = 5'd2;
                a_wdata = 32'h00000BAD;
                a_sb    = 1'b1;
                a_baddr = 5'd2;
                a_raddr = {5'd2, 5'd2};
                #1;
                chk("init_rdata_a", a_rdata, 64'd0);
                chk("init_rbusy_a", 64'(a_rbusy), 64'd0);
                chk("init_rdata_b", b_rdata, 64'd0);
            end
            if (c == 20) a_idle();
        end

        // Whole array cleared, INIT-time write/busy left no trace
        for (int r = 0; r < 32; r++) begin
            a_raddr = {5'(31 - r), 5'(r)};
            #1;
            chk("clear_a_p0", 64'(a_rdata[31:0]), 64'd0);
            chk("clear_a_p1", 64'(a_rdata[63:32]), 64'd0);
            chk("clear_a_busy", 64'(a_rbusy), 64'd0);
            chk("clear_b_p0", 64'(b_rdata[31:0]), 64'd0);
        end

        // Directed vector table
        tick();
        for (int i = 0; i < 13; i++) begin
            a_wen   = vecs[i].wen;
            a_waddr = vecs[i].wa;
            a_wdata = vecs[i].wd;
            a_sb    = vecs[i].sb;
            a_baddr = vecs[i].ba;
            a_raddr = {vecs[i].ra1, vecs[i].ra0};
            #1;
            chk($sformatf("vec%0d_a_d0", i), 64'(a_rdata[31:0]), 64'(vecs[i].ad0));
            chk($sformatf("vec%0d_a_b0", i), 64'(a_rbusy[0]), 64'(vecs[i].ab0));
            chk($sformatf("vec%0d_a_d1", i), 64'(a_rdata[63:32]), 64'(vecs[i].ad1));
            chk($sformatf("vec%0d_b_d0", i), 64'(b_rdata[31:0]), 64'(vecs[i].bd0));
            chk($sformatf("vec%0d_b_b0", i), 64'(b_rbusy[0]), 64'(vecs[i].bb0));
            chk($sformatf("vec%0d_b_d1", i), 64'(b_rdata[63:32]), 64'(vecs[i].bd1));
            tick();
        end

        // Mid-operation reset: x3 busy with value 7, then one reset edge
        a_wen   = 1'b1;
        a_waddr = 5'd3;
        a_wdata = 32'd7;
        a_sb    = 1'b1;
        a_baddr = 5'd3;
        a_raddr = {5'd3, 5'd3};
        tick();
        a_idle();
        #1;
        chk("pre_rst_x3_a", 64'(a_rdata[31:0]), 64'd7);
        chk("pre_rst_busy_a", 64'(a_rbusy[0]), 64'd1);
        chk("pre_rst_busy_b", 64'(b_rbusy[0]), 64'd1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_ready", 64'(a_ready), 64'd0);
        chk("mid_rst_rbusy", 64'(a_rbusy), 64'd0);
        chk("mid_rst_rdata", a_rdata, 64'd0);
        rst_n = 1'b1;
        cyc   = 0;
        while (!a_ready && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("mid_rst_sweep_len", 64'(cyc), 64'd32);
        chk("post_rst_x3_a", 64'(a_rdata[31:0]), 64'd0);
        chk("post_rst_busy_a", 64'(a_rbusy[0]), 64'd0);
        chk("post_rst_x3_b", 64'(b_rdata[31:0]), 64'd0);
        chk("post_rst_busy_b", 64'(b_rbusy[0]), 64'd0);

        // 4-port 64-bit random traffic against a reference model
        for (int k = 0; k < 16; k++) m[k] = '0;
        mb = '0;
        chk("c_ready_run", 64'(c_ready), 64'd1);
        for (int n = 0; n < 200; n++) begin
            c_wen   = 1'($urandom_range(0, 1));
            c_waddr = 4'($urandom_range(0, 15));
            c_wdata = {$urandom, $urandom};
            c_sb    = 1'($urandom_range(0, 1));
            c_baddr = 4'($urandom_range(0, 15));
            c_raddr = 16'($urandom);
            if ($urandom_range(0, 2) == 0) c_raddr[7:4] = c_waddr;
            if ($urandom_range(0, 3) == 0) c_raddr[15:12] = c_raddr[3:0];
            #1;
            for (int p = 0; p < 4; p++) begin
                logic [3:0]  ra;
                logic [63:0] ed;
                logic        eb;
                ra = c_raddr[p*4 +: 4];
                if (ra == 4'd0) begin
                    ed = '0;
                    eb = 1'b0;
                end else if (c_wen && c_waddr == ra) begin
                    ed = c_wdata;
                    eb = 1'b0;
                end else begin
                    ed = m[ra];
                    eb = mb[ra];
                end
                chk($sformatf("mp_d%0d_n%0d", p, n), c_rdata[p*64 +: 64], ed);
                chk($sformatf("mp_b%0d_n%0d", p, n), 64'(c_rbusy[p]), 64'(eb));
            end
            if (c_wen && c_waddr != 4'd0) m[c_waddr] = c_wdata;
            if (c_wen) mb[c_waddr] = 1'b0;
            if (c_sb) mb[c_baddr] = 1'b1;
            mb[0] = 1'b0;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised integer register file for the pipelined RISC-V core: configurable data width, register count and number of combinational read ports, with a single write-back port. Beyond a plain storage array, it adds write-to-read bypass, an optional hardwired zero register, and a per-register pending-write scoreboard for hazard detection. After reset, a sequential clear sweep zeroes the array so it can still map to RAM-style storage. It sits in decode, with reads issued from ID, `set_busy` driven from ID issue, and writes arriving from the MEM/WB stage.

## Interface
- `XLEN`, 32: data width in bits.
- `NREGS`, 32: register count; power of two, ≥2; `AW = $clog2(NREGS)`.
- `NREAD`, 2: number of read ports, ≥1.
- `BYPASS`, 1: 1 forwards same-cycle write data to matching reads.
- `ZERO_REG`, 1: 1 makes register 0 read as zero, ignore writes and never become busy.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous and active-low.
- `raddr`  in  NREAD*AW  packed read addresses; port i is `[i*AW +: AW]`.
- `rdata`  out  NREAD*XLEN  packed read data; port i is `[i*XLEN +: XLEN]`.
- `rbusy`  out  NREAD  1 means the register on read port i has a write outstanding.
- `wen`  in  1  write-back enable.
- `waddr`  in  AW  write address.
- `wdata`  in  XLEN  write data.
- `set_busy`  in  1  an issuing instruction will write `busy_addr`.
- `busy_addr`  in  AW  destination register of the issuing instruction.
- `ready`  out  1  clear sweep finished; block accepts traffic.

## Operation
- **States:** `INIT` and `RUN`.
  - `rst=0` at an edge: enter `INIT`, sweep counter to 0, all busy bits to 0, `ready` to 0.
  - `INIT`: each cycle with `rst=1`, write 0 to `mem[cnt]`, then increment `cnt`.
  - After `cnt==NREGS-1` is written, move to `RUN` and set `ready` to 1.
- **In `INIT`:**
  - `wen` and `set_busy` are ignored.
  - `rdata` is 0 on all ports and `rbusy` is 0.
- **Reads** (`RUN`, combinational, per port i):
  - `ZERO_REG=1` and `raddr_i==0`: `rdata_i` is 0.
  - Otherwise, if `BYPASS=1`, `wen=1` and `waddr==raddr_i`: `rdata_i = wdata`.
  - Otherwise: `rdata_i = mem[raddr_i]`.
- **Write:** `wen=1` in `RUN` stores `wdata` at `waddr` on the edge. The write is dropped if `ZERO_REG=1` and `waddr==0`.
- **Scoreboard:**
  - `busy[busy_addr]` is set on the edge when `set_busy=1`.
  - `busy[waddr]` is cleared on the edge when `wen=1`.
  - Same address set and cleared in the same cycle: the set wins, since the issuing instruction is younger.
  - With `ZERO_REG=1`, `busy[0]` is constant 0.
- **Busy output:** `rbusy_i = busy[raddr_i]`, except it is 0 when `BYPASS=1`, `wen=1` and `waddr==raddr_i`, because the data is forwarded this cycle.
- **Port independence:** all read ports are independent. Duplicate addresses across ports return identical data.

## Timing
- **Reset values:**
  - `ready` = 0.
  - All busy bits = 0.
  - `rdata` and `rbusy` = 0.
  - Array contents are undefined until the sweep writes them.
- **Sweep length:** with `rst` held high from edge 0, `ready` rises after edge `NREGS`, giving exactly `NREGS` cycles in `INIT`.
- **Reset mid-sweep or in `RUN`:** the sweep restarts from 0, all busy bits clear, and `ready` drops on that edge.
- **Read latency:** 0 cycles, combinational from `raddr`, `wen`, `waddr` and `wdata`.
- **Write latency:**
  - With `BYPASS=1`, the new value is visible the same cycle.
  - With `BYPASS=0`, it is visible the cycle after the edge.
- **Busy latency:** set becomes visible the cycle after the `set_busy` edge. Clear is visible the same cycle under `BYPASS=1`.
- **Address range:** all addresses in `0..NREGS-1` are valid, with no out-of-range wrap.

## Test plan
- **Reset sweep:** default parameters; hold `rst=0` for 3 cycles, then release.
  - `ready` goes 0→1 exactly 32 cycles later.
  - All 32 registers then read 0.
  - `wen` pulsed during `INIT` leaves no effect.
- **Write/read with bypass:** write `x5=0xDEADBEEF`, with `raddr0=5` in the same cycle.
  - `rdata0=0xDEADBEEF` in that cycle with `BYPASS=1`.
  - With `BYPASS=0`, the old value in that cycle and `0xDEADBEEF` on the next cycle.
- **Zero register:** write `x0=0x12345678` with `set_busy` on address 0.
  - `rdata` for address 0 stays 0 and `rbusy` stays 0.
  - With `ZERO_REG=0`, `x0` reads `0x12345678`.
- **Scoreboard:**
  - `set_busy` on x7: `rbusy` for x7 is 1 from the next cycle.
  - Write-back to x7: `rbusy=0` that cycle when `BYPASS=1`.
  - Same-cycle `set_busy` on x9 and `wen` to x9: x9 stays busy.
- **Mid-operation reset:** set x3 busy and write x3=7, then assert `rst` for 1 cycle.
  - `ready=0` and `rbusy=0` immediately.
  - After 32 cycles, x3 reads 0.
- **Multi-port:** `NREAD=4`, `XLEN=64`, `NREGS=16`; random writes and reads against a reference model.
  - Every port matches the model each cycle, including duplicate addresses across ports.
